instruction_decoder: RTL and testbench
======================================

# instruction_decoder

Decodes the 8-bit instruction returned by program memory and drives the program sequencer's control inputs (`jmp`, `jmp_nz`, `dont_jmp`, `jmp_addr`, `NOPC8`..`NOPDF`) plus the datapath register-load and source-select controls. It sits between program memory and the sequencer/computational unit, and owns the zero flag that gates conditional jumps. Decode is same-cycle. The instruction register, zero flag and optional counters are registered.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `sync_reset` in 1: synchronous, active-high reset.
- `pm_data` in 8: instruction at the current `pc`, from the registered-output program memory.
- `alu_zero` in 1: the computational unit's ALU result is zero (combinational).
- `jmp` out 1: unconditional jump.
- `jmp_nz` out 1: jump if not zero.
- `dont_jmp` out 1: equals `z_flag`; suppresses a `jmp_nz`.
- `jmp_addr` out 4: jump target nibble; the sequencer forms `{jmp_addr,4'd0}`.
- `NOPC8`, `NOPCF`, `NOPD8`, `NOPDF` out 1 each: reserved-NOP indicators.
- `reg_en` out 8: one-hot load enable for destinations 0..7 (x0,x1,y0,y1,o_reg,m,i,dm).
- `src_sel` out 4: data-bus source. 0..7 select registers. 8 selects the immediate `pm_data[3:0]`.
- `alu_op` out 5: the ALU function, `pm_data[4:0]`. Valid when `alu_en`=1.
- `alu_en` out 1: execute the ALU op and capture the result.
- `ir` out 8: registered copy of the last decoded instruction, for debug.
- `z_flag` out 1: the zero flag.

## Operation
- Encoding, decoded from `pm_data`:
  - `0ddd_iiii`: load immediate. Asserts `reg_en[ddd]` with `src_sel`=8.
  - `10dd_dsss`: move. Asserts `reg_en[ddd]` with `src_sel`=sss. When ddd==sss it is a NOP: `reg_en`=0.
  - `110x_xxxx`: ALU op. Asserts `alu_en` and `alu_op`=`pm_data[4:0]`. The codes 0xC8, 0xCF, 0xD8 and 0xDF are reserved NOPs:
    - the matching `NOPxx` output is 1;
    - `alu_en`=0;
    - no flag update.
  - `1110_aaaa`: `jmp`=1 and `jmp_addr`=aaaa.
  - `1111_aaaa`: `jmp_nz`=1 and `jmp_addr`=aaaa.
- For non-jump instructions `jmp_addr`=`pm_data[3:0]`, but it is ignored.
- Zero flag: when `alu_en`=1 at a clock edge, `z_flag` <= `alu_zero`. Otherwise `z_flag` holds.
- `dont_jmp` = `z_flag`, combinational from the register.
- `ir` <= `pm_data` every cycle.
- Reset while `sync_reset`=1:
  - all of `jmp`, `jmp_nz`, `reg_en`, `alu_en` and `NOPxx` are forced to 0 combinationally; `src_sel`=0;
  - at the edge, `z_flag` <= 0 and `ir` <= 0x00.
- Reset mid-instruction discards that instruction's effects, including any flag update on that edge.

## Timing
- Latency: decode outputs are combinational from `pm_data` in the same cycle. There is no pipeline bubble.
- A jump resolves in the cycle it is presented: the sequencer loads `{aaaa,0000}` at the next edge.
- Flag visibility: a `jnz` immediately following an ALU op sees that op's result, because the flag is updated at the edge between the two instructions.
- A `jnz` in the same cycle as an ALU op is impossible (exclusive opcodes).
- After `sync_reset` deasserts, the first `pm_data` is `mem[0]` and is valid at once. No blanking cycle.
- Reset values: `z_flag`=0, `dont_jmp`=0, `ir`=0x00. All enables and jump outputs are 0 during reset.

## Configuration
- `INSTR_COUNT_EN` defined:
  - adds outputs `instr_cnt` [15:0] and `jmp_taken_cnt` [15:0];
  - `instr_cnt` increments on every non-reset cycle;
  - `jmp_taken_cnt` increments when `jmp`=1, or when `jmp_nz`=1 with `z_flag`=0;
  - both wrap from 0xFFFF to 0x0000 and clear on `sync_reset`.
- Undefined: the ports and logic are absent. All other behaviour is identical.

## Structure
- Package `decoder_pkg` holds:
  - opcode-class constants (LOAD, MOVE, ALU, JMP, JNZ prefixes);
  - destination/source codes 0..7;
  - `SRC_IMM`=8;
  - reserved-NOP codes 0xC8, 0xCF, 0xD8, 0xDF.
- Sub-module `instr_counter` holds the two 16-bit counters and is instantiated only under `INSTR_COUNT_EN`.

## Test plan
- Reset: hold `sync_reset`=1 with `pm_data`=0xE5. Expect `jmp`=0, `reg_en`=0, `z_flag`=0 and, after the edge, `ir`=0x00.
- Load and move:
  - `pm_data`=0x37 → `reg_en`=0x08, `src_sel`=8;
  - 0x8A → `reg_en`=0x02, `src_sel`=2;
  - 0x92 → `reg_en`=0x00 (NOP).
- Jumps:
  - 0xE5 → `jmp`=1, `jmp_addr`=5;
  - 0xF9 with `z_flag`=0 → `jmp_nz`=1, `dont_jmp`=0.
- Flag then branch: 0xC1 with `alu_zero`=1, then next cycle 0xF3 → `dont_jmp`=1. Repeat with `alu_zero`=0 → `dont_jmp`=0.
- Reserved NOPs: each of 0xC8, 0xCF, 0xD8, 0xDF → only its `NOPxx`=1, `alu_en`=0, `z_flag` unchanged across the edge.
- With `INSTR_COUNT_EN`: 10 cycles containing 2 `jmp` and 1 `jnz` with `z_flag`=1 → `instr_cnt`=10, `jmp_taken_cnt`=2. Preload 0xFFFF → wraps to 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared opcode-class constants, register codes and decode helpers for instruction_decoder.
package decoder_pkg;

    // Opcode-class prefixes, left-aligned in the instruction byte.
    localparam logic [0:0] OPC_LOAD = 1'b0;
    localparam logic [1:0] OPC_MOVE = 2'b10;
    localparam logic [2:0] OPC_ALU  = 3'b110;
    localparam logic [3:0] OPC_JMP  = 4'b1110;
    localparam logic [3:0] OPC_JNZ  = 4'b1111;

    typedef enum logic [2:0] {
        CLS_LOAD,
        CLS_MOVE,
        CLS_ALU,
        CLS_JMP,
        CLS_JNZ
    } opc_class_e;

    typedef enum logic [2:0] {
        REG_X0 = 3'd0,
        REG_X1 = 3'd1,
        REG_Y0 = 3'd2,
        REG_Y1 = 3'd3,
        REG_O  = 3'd4,
        REG_M  = 3'd5,
        REG_I  = 3'd6,
        REG_DM = 3'd7
    } reg_code_e;

    localparam logic [3:0] SRC_IMM = 4'd8;

    localparam logic [7:0] NOP_C8 = 8'hC8;
    localparam logic [7:0] NOP_CF = 8'hCF;
    localparam logic [7:0] NOP_D8 = 8'hD8;
    localparam logic [7:0] NOP_DF = 8'hDF;

    // Decoded control bundle; nop is ordered {C8, CF, D8, DF}.
    typedef struct packed {
        logic       jmp;
        logic       jmp_nz;
        logic [7:0] reg_en;
        logic [3:0] src_sel;
        logic       alu_en;
        logic [3:0] nop;
    } decode_t;

    function automatic opc_class_e opc_class(input logic [7:0] instr);
        if (instr[7] == OPC_LOAD)
            return CLS_LOAD;
        else if (instr[7:6] == OPC_MOVE)
            return CLS_MOVE;
        else if (instr[7:5] == OPC_ALU)
            return CLS_ALU;
        else if (instr[7:4] == OPC_JMP)
            return CLS_JMP;
        else
            return CLS_JNZ;
    endfunction

    function automatic logic [7:0] dest_onehot(input reg_code_e code);
        return 8'b1 << code;
    endfunction

endpackage

// File: rtl/instruction_decoder_if.sv
// Control bus between program memory, instruction_decoder and the sequencer/datapath.
// Counter signals exist only when INSTR_COUNT_EN is defined.
interface instruction_decoder_if;

    logic [7:0]  pm_data;
    logic        alu_zero;
    logic        jmp;
    logic        jmp_nz;
    logic        dont_jmp;
    logic [3:0]  jmp_addr;
    logic        NOPC8;
    logic        NOPCF;
    logic        NOPD8;
    logic        NOPDF;
    logic [7:0]  reg_en;
    logic [3:0]  src_sel;
    logic [4:0]  alu_op;
    logic        alu_en;
    logic [7:0]  ir;
    logic        z_flag;
`ifdef INSTR_COUNT_EN
    logic [15:0] instr_cnt;
    logic [15:0] jmp_taken_cnt;
`endif

`ifdef INSTR_COUNT_EN
    modport master (
        input  pm_data, alu_zero,
        output jmp, jmp_nz, dont_jmp, jmp_addr,
        output NOPC8, NOPCF, NOPD8, NOPDF,
        output reg_en, src_sel, alu_op, alu_en, ir, z_flag,
        output instr_cnt, jmp_taken_cnt
    );

    modport slave (
        output pm_data, alu_zero,
        input  jmp, jmp_nz, dont_jmp, jmp_addr,
        input  NOPC8, NOPCF, NOPD8, NOPDF,
        input  reg_en, src_sel, alu_op, alu_en, ir, z_flag,
        input  instr_cnt, jmp_taken_cnt
    );
`else
    modport master (
        input  pm_data, alu_zero,
        output jmp, jmp_nz, dont_jmp, jmp_addr,
        output NOPC8, NOPCF, NOPD8, NOPDF,
        output reg_en, src_sel, alu_op, alu_en, ir, z_flag
    );

    modport slave (
        output pm_data, alu_zero,
        input  jmp, jmp_nz, dont_jmp, jmp_addr,
        input  NOPC8, NOPCF, NOPD8, NOPDF,
        input  reg_en, src_sel, alu_op, alu_en, ir, z_flag
    );
`endif

endinterface

// File: rtl/instr_counter.sv
// Free-running instruction and taken-jump counters; only instantiated under INSTR_COUNT_EN.
module instr_counter (
    input  logic        clk,
    input  logic        sync_reset,
    input  logic        jmp_i,
    input  logic        jmp_nz_i,
    input  logic        z_flag_i,
    output logic [15:0] instr_cnt_o,
    output logic [15:0] jmp_taken_cnt_o
);

    logic [15:0] instr_cnt_d, instr_cnt_q;
    logic [15:0] jmp_taken_cnt_d, jmp_taken_cnt_q;
    logic        taken;

    // A conditional jump is taken only while the zero flag is clear.
    assign taken = jmp_i | (jmp_nz_i & ~z_flag_i);

    always_comb begin
        instr_cnt_d     = instr_cnt_q + 16'd1;
        jmp_taken_cnt_d = jmp_taken_cnt_q;
        if (taken)
            jmp_taken_cnt_d = jmp_taken_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            instr_cnt_q     <= '0;
            jmp_taken_cnt_q <= '0;
        end else begin
            instr_cnt_q     <= instr_cnt_d;
            jmp_taken_cnt_q <= jmp_taken_cnt_d;
        end
    end

    assign instr_cnt_o     = instr_cnt_q;
    assign jmp_taken_cnt_o = jmp_taken_cnt_q;

endmodule

// File: rtl/instruction_decoder.sv
// Same-cycle 8-bit instruction decoder owning the zero flag and instruction register.
// Optional counters are enabled by defining INSTR_COUNT_EN.
module instruction_decoder
    import decoder_pkg::*;
(
    input  logic                  clk,
    input  logic                  sync_reset,
    instruction_decoder_if.master bus
);

    opc_class_e cls;
    decode_t    dec;
    logic [7:0] ir_d, ir_q;
    logic       z_flag_d, z_flag_q;

    always_comb begin
        // NOTE: every field is defaulted before the case, so no path can infer a latch.
        dec = '0;
        cls = opc_class(bus.pm_data);
        if (!sync_reset) begin
            unique case (cls)
                CLS_LOAD: begin
                    dec.reg_en  = dest_onehot(reg_code_e'(bus.pm_data[6:4]));
                    dec.src_sel = SRC_IMM;
                end
                CLS_MOVE: begin
                    dec.src_sel = {1'b0, bus.pm_data[2:0]};
                    if (bus.pm_data[5:3] != bus.pm_data[2:0])
                        dec.reg_en = dest_onehot(reg_code_e'(bus.pm_data[5:3]));
                end
                CLS_ALU: begin
                    unique case (bus.pm_data)
                        NOP_C8:  dec.nop[3] = 1'b1;
                        NOP_CF:  dec.nop[2] = 1'b1;
                        NOP_D8:  dec.nop[1] = 1'b1;
                        NOP_DF:  dec.nop[0] = 1'b1;
                        default: dec.alu_en = 1'b1;
                    endcase
                end
                CLS_JMP: dec.jmp    = 1'b1;
                CLS_JNZ: dec.jmp_nz = 1'b1;
                default: ;
            endcase
        end
    end

    // Flag follows the ALU only on real ALU ops; reserved NOPs leave it alone.
    always_comb begin
        ir_d     = bus.pm_data;
        z_flag_d = z_flag_q;
        if (dec.alu_en)
            z_flag_d = bus.alu_zero;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (sync_reset) begin
            ir_q     <= 8'h00;
            z_flag_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            z_flag_q <= z_flag_d;
        end
    end

    assign bus.jmp      = dec.jmp;
    assign bus.jmp_nz   = dec.jmp_nz;
    assign bus.jmp_addr = bus.pm_data[3:0];
    assign bus.reg_en   = dec.reg_en;
    assign bus.src_sel  = dec.src_sel;
    assign bus.alu_op   = bus.pm_data[4:0];
    assign bus.alu_en   = dec.alu_en;
    assign bus.NOPC8    = dec.nop[3];
    assign bus.NOPCF    = dec.nop[2];
    assign bus.NOPD8    = dec.nop[1];
    assign bus.NOPDF    = dec.nop[0];
    assign bus.ir       = ir_q;
    assign bus.z_flag   = z_flag_q;
    assign bus.dont_jmp = z_flag_q;

`ifdef INSTR_COUNT_EN
    instr_counter u_instr_counter (
        .clk             (clk),
        .sync_reset      (sync_reset),
        .jmp_i           (dec.jmp),
        .jmp_nz_i        (dec.jmp_nz),
        .z_flag_i        (z_flag_q),
        .instr_cnt_o     (bus.instr_cnt),
        .jmp_taken_cnt_o (bus.jmp_taken_cnt)
    );
`endif

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: directed scenarios plus randomized
// instructions compared against an arithmetic reference model.
module tb_instruction_decoder;

    typedef struct packed {
        logic       jmp;
        logic       jmp_nz;
        logic [3:0] jmp_addr;
        logic [3:0] nop;
        logic [7:0] reg_en;
        logic [3:0] src_sel;
        logic [4:0] alu_op;
        logic       alu_en;
    } ctl_t;

    logic clk = 1'b0;
    logic sync_reset;
    instruction_decoder_if bus();

    instruction_decoder dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       model_z;
    logic [7:0] model_ir;
`ifdef INSTR_COUNT_EN
    logic [15:0] model_cnt;
    logic [15:0] model_taken;
`endif

    // Expected controls straight from the encoding table, using plain arithmetic.
    function automatic ctl_t model(input int unsigned instr);
        ctl_t e;
        int unsigned d, s;
        e = '0;
        e.jmp_addr = 4'(instr % 16);
        e.alu_op   = 5'(instr % 32);
        if (instr < 128) begin
            e.reg_en  = 8'(1 << (instr / 16));
            e.src_sel = 4'd8;
        end else if (instr < 192) begin
            d = (instr / 8) % 8;
            s = instr % 8;
            e.src_sel = 4'(s);
            e.reg_en  = (d == s) ? 8'h00 : 8'(1 << d);
        end else if (instr < 224) begin
            case (instr)
                200:     e.nop = 4'b1000;
                207:     e.nop = 4'b0100;
                216:     e.nop = 4'b0010;
                223:     e.nop = 4'b0001;
                default: e.alu_en = 1'b1;
            endcase
        end else if (instr < 240) begin
            e.jmp = 1'b1;
        end else begin
            e.jmp_nz = 1'b1;
        end
        return e;
    endfunction

    function automatic ctl_t observed();
        ctl_t a;
        a.jmp      = bus.jmp;
        a.jmp_nz   = bus.jmp_nz;
        a.jmp_addr = bus.jmp_addr;
        a.nop      = {bus.NOPC8, bus.NOPCF, bus.NOPD8, bus.NOPDF};
        a.reg_en   = bus.reg_en;
        a.src_sel  = bus.src_sel;
        a.alu_op   = bus.alu_op;
        a.alu_en   = bus.alu_en;
        return a;
    endfunction

    task automatic drive(input logic [7:0] instr, input logic zero);
        bus.pm_data  = instr;
        bus.alu_zero = zero;
        #2;
    endtask

    // Advance one edge and update the model state from what was presented.
    task automatic clock_edge();
        ctl_t e;
        e = model(int'(bus.pm_data));
        if (sync_reset) begin
            model_z  = 1'b0;
            model_ir = 8'h00;
`ifdef INSTR_COUNT_EN
            model_cnt   = 16'h0000;
            model_taken = 16'h0000;
`endif
        end else begin
`ifdef INSTR_COUNT_EN
            model_cnt = model_cnt + 16'd1;
            if (e.jmp || (e.jmp_nz && !model_z))
                model_taken = model_taken + 16'd1;
`endif
            if (e.alu_en)
                model_z = bus.alu_zero;
            model_ir = bus.pm_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        sync_reset = 1'b1;
        drive(8'hE5, 1'b1);
        checks++;
        if (bus.jmp !== 1'b0 || bus.jmp_nz !== 1'b0) begin
            errors++;
            $display("FAIL reset_jumps: jmp=%b jmp_nz=%b expected 0 0", bus.jmp, bus.jmp_nz);
        end
        checks++;
        if (bus.reg_en !== 8'h00 || bus.src_sel !== 4'd0) begin
            errors++;
            $display("FAIL reset_reg: reg_en=%h src_sel=%h expected 00 0", bus.reg_en, bus.src_sel);
        end
        drive(8'hC8, 1'b1);
        checks++;
        if (bus.alu_en !== 1'b0 || bus.NOPC8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_alu: alu_en=%b NOPC8=%b expected 0 0", bus.alu_en, bus.NOPC8);
        end
        drive(8'hC1, 1'b1);
        clock_edge();
        checks++;
        if (bus.ir !== 8'h00 || bus.z_flag !== 1'b0 || bus.dont_jmp !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ir=%h z_flag=%b dont_jmp=%b expected 00 0 0",
                     bus.ir, bus.z_flag, bus.dont_jmp);
        end
        sync_reset = 1'b0;
    endtask

    task automatic test_load_move();
        logic [7:0] instrs [3] = '{8'h37, 8'h8A, 8'h92};
        ctl_t e;
        for (int i = 0; i < 3; i++) begin
            drive(instrs[i], 1'b0);
            e = model(int'(instrs[i]));
            checks++;
            if (bus.reg_en !== e.reg_en || bus.src_sel !== e.src_sel) begin
                errors++;
                $display("FAIL load_move_%h: reg_en=%h src_sel=%h expected %h %h",
                         instrs[i], bus.reg_en, bus.src_sel, e.reg_en, e.src_sel);
            end
            clock_edge();
            checks++;
            if (bus.ir !== model_ir) begin
                errors++;
                $display("FAIL ir_%h: ir=%h expected %h", instrs[i], bus.ir, model_ir);
            end
        end
    endtask

    task automatic test_jumps();
        drive(8'hE5, 1'b0);
        checks++;
        if (bus.jmp !== 1'b1 || bus.jmp_nz !== 1'b0 || bus.jmp_addr !== 4'd5) begin
            errors++;
            $display("FAIL jmp_E5: jmp=%b jmp_nz=%b addr=%h expected 1 0 5",
                     bus.jmp, bus.jmp_nz, bus.jmp_addr);
        end
        clock_edge();
        drive(8'hF9, 1'b0);
        checks++;
        if (bus.jmp_nz !== 1'b1 || bus.jmp !== 1'b0 || bus.jmp_addr !== 4'd9 ||
            bus.dont_jmp !== model_z) begin
            errors++;
            $display("FAIL jnz_F9: jmp_nz=%b jmp=%b addr=%h dont_jmp=%b expected 1 0 9 %b",
                     bus.jmp_nz, bus.jmp, bus.jmp_addr, bus.dont_jmp, model_z);
        end
        clock_edge();
    endtask

    task automatic test_flag_branch();
        logic zero_vals [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            drive(8'hC1, zero_vals[i]);
            checks++;
            if (bus.alu_en !== 1'b1 || bus.alu_op !== 5'h01) begin
                errors++;
                $display("FAIL alu_C1: alu_en=%b alu_op=%h expected 1 01", bus.alu_en, bus.alu_op);
            end
            clock_edge();
            drive(8'hF3, 1'b0);
            checks++;
            if (bus.dont_jmp !== zero_vals[i] || bus.jmp_nz !== 1'b1) begin
                errors++;
                $display("FAIL flag_branch_%0d: dont_jmp=%b jmp_nz=%b expected %b 1",
                         i, bus.dont_jmp, bus.jmp_nz, zero_vals[i]);
            end
            clock_edge();
        end
    endtask

    task automatic test_reserved_nops();
        logic [7:0] codes [4] = '{8'hC8, 8'hCF, 8'hD8, 8'hDF};
        logic [3:0] nops;
        drive(8'hC0, 1'b1);
        clock_edge();
        for (int i = 0; i < 4; i++) begin
            drive(codes[i], 1'b0);
            nops = {bus.NOPC8, bus.NOPCF, bus.NOPD8, bus.NOPDF};
            checks++;
            if (nops !== 4'(8 >> i) || bus.alu_en !== 1'b0 || bus.reg_en !== 8'h00 ||
                bus.jmp !== 1'b0 || bus.jmp_nz !== 1'b0) begin
                errors++;
                $display("FAIL nop_%h: nops=%b alu_en=%b reg_en=%h expected %b 0 00",
                         codes[i], nops, bus.alu_en, bus.reg_en, 4'(8 >> i));
            end
            clock_edge();
            checks++;
            if (bus.z_flag !== 1'b1) begin
                errors++;
                $display("FAIL nop_flag_%h: z_flag=%b expected 1", codes[i], bus.z_flag);
            end
        end
    endtask

    task automatic test_reset_mid();
        sync_reset = 1'b1;
        drive(8'hC3, 1'b1);
        clock_edge();
        checks++;
        if (bus.z_flag !== 1'b0 || bus.ir !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: z_flag=%b ir=%h expected 0 00", bus.z_flag, bus.ir);
        end
        sync_reset = 1'b0;
        drive(8'hE7, 1'b0);
        checks++;
        if (bus.jmp !== 1'b1 || bus.jmp_addr !== 4'd7) begin
            errors++;
            $display("FAIL first_after_reset: jmp=%b addr=%h expected 1 7", bus.jmp, bus.jmp_addr);
        end
        clock_edge();
    endtask

    task automatic test_random();
        ctl_t e, a;
        logic [7:0] instr;
        for (int n = 0; n < 300; n++) begin
            instr = 8'($urandom_range(255));
            drive(instr, 1'($urandom_range(1)));
            e = model(int'(instr));
            a = observed();
            checks++;
            if (a !== e || bus.dont_jmp !== model_z) begin
                errors++;
                $display("FAIL random_decode_%h: got %h dont_jmp=%b expected %h dont_jmp=%b",
                         instr, a, bus.dont_jmp, e, model_z);
            end
            clock_edge();
            checks++;
            if (bus.z_flag !== model_z || bus.ir !== model_ir) begin
                errors++;
                $display("FAIL random_state_%h: z_flag=%b ir=%h expected %b %h",
                         instr, bus.z_flag, bus.ir, model_z, model_ir);
            end
        end
    endtask

`ifdef INSTR_COUNT_EN
    task automatic test_counters();
        logic [7:0] prog [10] = '{8'hC1, 8'hE0, 8'h00, 8'hF0, 8'hE1,
                                  8'h10, 8'h20, 8'h88, 8'hC0, 8'h30};
        sync_reset = 1'b1;
        drive(8'h00, 1'b0);
        clock_edge();
        sync_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(prog[i], 1'b1);
            clock_edge();
        end
        checks++;
        if (bus.instr_cnt !== model_cnt || bus.jmp_taken_cnt !== model_taken) begin
            errors++;
            $display("FAIL counters: instr_cnt=%0d jmp_taken_cnt=%0d expected %0d %0d",
                     bus.instr_cnt, bus.jmp_taken_cnt, model_cnt, model_taken);
        end
        drive(8'h00, 1'b0);
        for (int i = 0; i < 65526; i++)
            clock_edge();
        checks++;
        if (bus.instr_cnt !== model_cnt || bus.jmp_taken_cnt !== model_taken) begin
            errors++;
            $display("FAIL counter_wrap: instr_cnt=%h jmp_taken_cnt=%h expected %h %h",
                     bus.instr_cnt, bus.jmp_taken_cnt, model_cnt, model_taken);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sync_reset   = 1'b1;
        bus.pm_data  = 8'h00;
        bus.alu_zero = 1'b0;
        #1;
        test_reset();
        test_load_move();
        test_jumps();
        test_flag_branch();
        test_reserved_nops();
        test_reset_mid();
        test_random();
`ifdef INSTR_COUNT_EN
        test_counters();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
